// File: rtl/count_mon_pkg.sv
// Shared types and constants for the count threshold monitor.
// State codes, counter widths and the default alarm hold time.
package count_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_ALARM = 2'b10
    } state_e;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned HIT_W = 8;
    localparam logic [HIT_W-1:0] HIT_SAT = 8'd255;
    localparam int unsigned HOLD_CYCLES_DEF = 4;
    localparam int unsigned HOLD_W = 8;

endpackage

// File: rtl/change_detector.sv
// Tracks the previous count and flags changes (and 15->0 wraps
// when COUNT_MON_WRAP_DETECT_EN is defined).
module change_detector
    import count_mon_pkg::*;
(
    input  logic             ClockIn,
    input  logic             Reset,
    input  logic [CNT_W-1:0] CounterValue,
`ifdef COUNT_MON_WRAP_DETECT_EN
    output logic             wrap_o,
`endif
    output logic             evt_o
);

    logic [CNT_W-1:0] prev_q;

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= CounterValue;
        end
    end

    assign evt_o = (CounterValue != prev_q);

`ifdef COUNT_MON_WRAP_DETECT_EN
    assign wrap_o = (prev_q == '1) && (CounterValue == '0);
`endif

endmodule

// File: rtl/count_threshold_monitor.sv
// Arms on Arm, raises Alarm on a fresh threshold match, holds it for
// HOLD_CYCLES. Optional wrap pulse under COUNT_MON_WRAP_DETECT_EN.
module count_threshold_monitor
    import count_mon_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
)
(
    input  logic             ClockIn,
    input  logic             Reset,
    input  logic [CNT_W-1:0] CounterValue,
    input  logic [CNT_W-1:0] Threshold,
    input  logic             Arm,
    input  logic             Ack,
    output logic             Alarm,
    output logic [1:0]       State,
    output logic             Changed,
    output logic [HIT_W-1:0] HitCount,
    output logic             Wrap
);

    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HIT_W-1:0]  hit_q, hit_d;
    logic              alarm_q;
    logic              changed_q;
    logic              evt;

`ifdef COUNT_MON_WRAP_DETECT_EN
    logic wrap_evt;
    logic wrap_q;

    change_detector u_det (
        .ClockIn      (ClockIn),
        .Reset        (Reset),
        .CounterValue (CounterValue),
        .wrap_o       (wrap_evt),
        .evt_o        (evt)
    );

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= evt && wrap_evt;
        end
    end

    assign Wrap = wrap_q;
`else
    change_detector u_det (
        .ClockIn      (ClockIn),
        .Reset        (Reset),
        .CounterValue (CounterValue),
        .evt_o        (evt)
    );

    assign Wrap = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        hit_d   = hit_q;
        case (state_q)
            ST_IDLE: begin
                if (Arm) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!Arm) begin
                    state_d = ST_IDLE;
                end else if (evt && (CounterValue == Threshold)) begin
                    state_d = ST_ALARM;
                    hold_d  = HOLD_INIT;
                    if (hit_q != HIT_SAT) begin
                        hit_d = hit_q + 1'b1;
                    end
                end
            end
            ST_ALARM: begin
                // Ack before the hold expires is dropped, not queued
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else if (Ack) begin
                    state_d = Arm ? ST_ARMED : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            hit_q     <= '0;
            alarm_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            hit_q     <= hit_d;
            alarm_q   <= (state_d == ST_ALARM);
            changed_q <= evt;
        end
    end

    assign Alarm    = alarm_q;
    assign State    = state_q;
    assign Changed  = changed_q;
    assign HitCount = hit_q;

endmodule

// File: tb/tb_count_threshold_monitor.sv
// Self-checking bench: directed scenarios plus random stimulus,
// compared every cycle against a behavioural model.
module tb_count_threshold_monitor;

    localparam int HOLD = 4;
`ifdef COUNT_MON_WRAP_DETECT_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic       ClockIn = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] CounterValue = '0;
    logic [3:0] Threshold = '0;
    logic       Arm = 1'b0;
    logic       Ack = 1'b0;
    logic       Alarm;
    logic [1:0] State;
    logic       Changed;
    logic [7:0] HitCount;
    logic       Wrap;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    count_threshold_monitor #(.HOLD_CYCLES(HOLD)) dut (
        .ClockIn      (ClockIn),
        .Reset        (Reset),
        .CounterValue (CounterValue),
        .Threshold    (Threshold),
        .Arm          (Arm),
        .Ack          (Ack),
        .Alarm        (Alarm),
        .State        (State),
        .Changed      (Changed),
        .HitCount     (HitCount),
        .Wrap         (Wrap)
    );

    always #5 ClockIn = ~ClockIn;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: 0=idle 1=armed 2=alarm; alarm age counts cycles spent in alarm
    int m_state = 0;
    int m_age = 0;
    int m_prev = 0;
    int m_hits = 0;
    int m_changed = 0;
    int m_wrap = 0;

    always @(posedge ClockIn) begin
        int cv;
        bit ev;
        cv = int'(CounterValue);
        if (Reset) begin
            m_state = 0;
            m_age = 0;
            m_prev = 0;
            m_hits = 0;
            m_changed = 0;
            m_wrap = 0;
        end else begin
            ev = (cv != m_prev);
            m_changed = ev ? 1 : 0;
            m_wrap = (WRAP_EN && ev && m_prev == 15 && cv == 0) ? 1 : 0;
            if (m_state == 0) begin
                if (Arm) m_state = 1;
            end else if (m_state == 1) begin
                if (!Arm) begin
                    m_state = 0;
                end else if (ev && cv == int'(Threshold)) begin
                    m_state = 2;
                    m_age = 1;
                    m_hits = (m_hits >= 255) ? 255 : m_hits + 1;
                end
            end else begin
                if (m_age >= HOLD && Ack) m_state = Arm ? 1 : 0;
                else if (m_age < HOLD) m_age++;
            end
            m_prev = cv;
        end
    end

    always @(negedge ClockIn) begin
        if (check_en) begin
            chk("model_state", int'(State), m_state);
            chk("model_alarm", int'(Alarm), (m_state == 2) ? 1 : 0);
            chk("model_changed", int'(Changed), m_changed);
            chk("model_hits", int'(HitCount), m_hits);
            chk("model_wrap", int'(Wrap), m_wrap);
        end
    end

    task automatic tick();
        @(negedge ClockIn);
    endtask

    initial begin
        int n;
        int cv;
        tick();
        tick();
        check_en = 1'b1;
        chk("reset_state", int'(State), 0);
        chk("reset_alarm", int'(Alarm), 0);
        chk("reset_hits", int'(HitCount), 0);
        chk("reset_changed", int'(Changed), 0);

        // Zero right after reset is not a change
        Reset = 1'b0;
        tick();
        chk("zero_after_reset", int'(Changed), 0);

        // Basic trigger on 3,4,5 with threshold 5
        Arm = 1'b1;
        Threshold = 4'd5;
        CounterValue = 4'd3;
        tick();
        chk("armed", int'(State), 1);
        chk("changed_3", int'(Changed), 1);
        CounterValue = 4'd4;
        tick();
        chk("no_alarm_4", int'(Alarm), 0);
        CounterValue = 4'd5;
        tick();
        chk("alarm_state", int'(State), 2);
        chk("alarm_high", int'(Alarm), 1);
        chk("hits_1", int'(HitCount), 1);

        // Ack held from entry: alarm lasts exactly HOLD cycles
        Ack = 1'b1;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (Alarm) n++;
            else break;
        end
        chk("alarm_len", n, 4);
        chk("back_armed", int'(State), 1);
        Ack = 1'b0;

        // Static equal value while arming must not trigger
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        Arm = 1'b0;
        CounterValue = 4'd5;
        tick();
        Arm = 1'b1;
        tick();
        tick();
        tick();
        chk("static_eq", int'(State), 1);
        CounterValue = 4'd6;
        tick();
        CounterValue = 4'd5;
        tick();
        chk("reenter_alarm", int'(State), 2);

        // Arm dropped during alarm selects idle exit; early Ack ignored
        Arm = 1'b0;
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("still_alarm", int'(State), 2);
        Ack = 1'b1;
        tick();
        chk("exit_idle", int'(State), 0);
        Ack = 1'b0;
        CounterValue = 4'd6;
        tick();
        CounterValue = 4'd5;
        Arm = 1'b1;
        tick();
        chk("arm_match_same", int'(State), 1);
        chk("arm_match_noalarm", int'(Alarm), 0);

        // Saturation of the hit counter
        Ack = 1'b1;
        for (int i = 0; i < 300; i++) begin
            CounterValue = 4'd6;
            tick();
            CounterValue = 4'd5;
            tick();
            for (int j = 0; j < HOLD; j++) tick();
        end
        chk("hits_sat", int'(HitCount), 255);
        CounterValue = 4'd6;
        tick();
        CounterValue = 4'd5;
        tick();
        chk("sat_alarm", int'(State), 2);
        chk("hits_stay", int'(HitCount), 255);
        Reset = 1'b1;
        tick();
        chk("reset_abort", int'(State), 0);
        chk("reset_abort_alarm", int'(Alarm), 0);
        chk("reset_abort_hits", int'(HitCount), 0);
        Reset = 1'b0;
        Ack = 1'b0;
        Arm = 1'b0;

        // Wrap 14,15,0
        CounterValue = 4'd14;
        tick();
        CounterValue = 4'd15;
        tick();
        chk("no_wrap_15", int'(Wrap), 0);
        CounterValue = 4'd0;
        tick();
        chk("wrap_changed", int'(Changed), 1);
        chk("wrap_pulse", int'(Wrap), WRAP_EN ? 1 : 0);
        tick();
        chk("wrap_gone", int'(Wrap), 0);
        chk("changed_gone", int'(Changed), 0);

        // Randomized run
        cv = 0;
        for (int i = 0; i < 4000; i++) begin
            Reset = ($urandom_range(0, 199) == 0);
            Arm = ($urandom_range(0, 7) != 0);
            Ack = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 63) == 0) Threshold = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: cv = int'(Threshold);
                1: cv = (cv + 1) % 16;
                2: cv = cv;
                default: cv = $urandom_range(0, 15);
            endcase
            CounterValue = 4'(cv);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_threshold_monitor.md
COUNT_THRESHOLD_MONITOR -- requirements
Module: count_threshold_monitor

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, minimum ClockIn cycles Alarm stays high after entry; legal range 1..255.
REQ-002 ClockIn  in  1  clock; all state changes on the rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 CounterValue  in  4  count stream from the upstream speed-divided counter.
REQ-005 Threshold  in  4  value that raises the alarm.
REQ-006 Arm  in  1  level; enables monitoring.
REQ-007 Ack  in  1  level/pulse; clears the alarm once the hold time has expired.
REQ-008 Alarm  out  1  high while the FSM is in ALARM.
REQ-009 State  out  2  FSM code: IDLE=00, ARMED=01, ALARM=10; 11 is unused.
REQ-010 Changed  out  1  one-cycle pulse per CounterValue change.
REQ-011 HitCount  out  8  saturating count of alarm entries.
REQ-012 Wrap  out  1  one-cycle wrap pulse (see Configuration); the port is always present.

Function
REQ-013 Register prev_q <= CounterValue every edge; event = (CounterValue != prev_q), sampled at the edge.
REQ-014 Changed is registered: it is high in the cycle after the edge at which event was true, and low otherwise.
REQ-015 IDLE -> ARMED at an edge with Arm=1; no alarm can trigger on that same edge, even if there is a match.
REQ-016 ARMED -> IDLE at an edge with Arm=0; Arm=0 takes priority over a match.
REQ-017 ARMED -> ALARM at an edge with Arm=1, event=1 and CounterValue==Threshold; a static equal value never triggers.
REQ-018 Entering ALARM loads hold_q with HOLD_CYCLES-1, and hold_q decrements each cycle in ALARM until it reaches 0.
REQ-019 Exit from ALARM happens at an edge where hold_q==0 and Ack=1; the next state is ARMED if Arm=1, otherwise IDLE.
REQ-020 Ack while hold_q!=0 is ignored and is not remembered; Ack held high exits on the first eligible edge.
REQ-021 Arm deassertion during ALARM does not leave ALARM; it only selects the exit target.
REQ-022 Events during ALARM neither re-trigger nor reload hold_q.
REQ-023 HitCount increments by 1 on each ARMED->ALARM transition and saturates at 255 (no wrap).
REQ-024 The State code 11 is unreachable; if it is reached, the next edge goes to IDLE.
REQ-025 Alarm and State are registered outputs; Alarm is asserted in the cycle after the triggering edge.

Reset
REQ-026 Reset=1 at an edge sets State=IDLE, Alarm=0, Changed=0, Wrap=0, HitCount=0, hold_q=0 and prev_q=0, overriding all other inputs.
REQ-027 Reset during ALARM aborts the alarm immediately, with no hold time honoured.
REQ-028 Because prev_q=0 after reset, a CounterValue of 0 in the first cycle after reset produces no event.

Configuration
REQ-029 Macro COUNT_MON_WRAP_DETECT_EN defined: Wrap pulses for one cycle, with the same timing as Changed, on an event where prev_q==15 and CounterValue==0.
REQ-030 Macro COUNT_MON_WRAP_DETECT_EN undefined: Wrap is tied to 0 and no wrap logic is synthesized; all other behaviour is identical.

Structure
REQ-031 Shared package count_mon_pkg holds: the State codes (IDLE/ARMED/ALARM), the HitCount width (8), the saturation value (255) and the HOLD_CYCLES default.
REQ-032 One sub-module, change_detector, holds prev_q and produces the event and wrap qualifiers; the FSM, hold counter and HitCount stay in the top module.

Verification
REQ-033 The bench covers these directed scenarios:
- Reset, Arm=1, Threshold=5, CounterValue steps 3,4,5 -> ALARM entered at the edge sampling 5; Alarm=1 in the next cycle; HitCount=1.
- CounterValue held at 5 while entering ARMED -> no alarm; after changing to 6 then back to 5 -> alarm.
- HOLD_CYCLES=4, Ack=1 continuously from ALARM entry -> Alarm high for exactly 4 cycles, then State=ARMED.
- Arm dropped during ALARM, then Ack after hold -> State=IDLE; Arm and match at the same edge from IDLE -> ARMED only.
- 300 forced alarm cycles -> HitCount=255 and stays at 255; Reset mid-ALARM -> IDLE, HitCount=0 at the next cycle.
- With COUNT_MON_WRAP_DETECT_EN, CounterValue 14,15,0 -> one Wrap pulse aligned with Changed; without the macro, Wrap stays 0.
